dm_ctrl: RTL and testbench
==========================

# dm_ctrl

Parametrised single-port data memory for the pipelined CPU's MEM stage, successor to the fixed 3072-word DM. Adds unsigned sub-word loads, a registered read with a valid handshake, misalignment and out-of-range error reporting, a configurable base address, and a clear sequencer that zeroes memory one word per cycle after reset.

## Interface

Parameters:
- DEPTH, 3072: number of 32-bit words; index width IDX_W = clog2(DEPTH).
- BASE, 32'h0000_0000: byte address of word 0; must be word-aligned.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present this cycle.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_op  in  3  000 word, 001 byte signed, 010 half signed, 011 byte unsigned, 100 half unsigned; others illegal.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; sub-word stores use the low bits.
- rsp_valid  out  1  response for the request accepted on the previous cycle.
- rsp_rdata  out  32  load result, zero- or sign-extended; 0 for stores and errors.
- rsp_err  out  1  request was misaligned, out of range, or used an illegal op.
- busy  out  1  clear sequence in progress.

## Operation

- States: CLEAR, IDLE.
- The reset edge enters CLEAR with clear pointer 0.
- CLEAR writes 0 to word[ptr] and increments ptr each cycle.
  - After word DEPTH-1 is written, the next state is IDLE.
  - req_ready = 0 and busy = 1 throughout CLEAR.
- IDLE: req_ready = 1 and busy = 0.
- Address decode: off = req_addr - BASE (32-bit wrap), idx = off[IDX_W+1:2], lane = off[1:0].
- Error when any of the following holds:
  - off >= 4*DEPTH (wrapped addresses below BASE included);
  - word op and lane != 0;
  - half op and lane[0] = 1;
  - illegal op.
- An error store does not modify memory. An error load returns rdata 0.
- Store word: full word written.
- Store half: lane[1] selects bits 15:0 or 31:16; the other half is preserved.
- Store byte: lane selects byte 0..3; the other bytes are preserved.
  - Implemented as a 4-bit byte enable; no read-modify-write cycle.
- Load: the word is read at the accept edge. The selected byte or half is extended per op (signed ops replicate the MSB, unsigned ops fill zeros).
  - Byte/half selection is the same as for the old DM.
- Every accepted request, load or store, produces exactly one response.

## Timing

- Reset values: rsp_valid 0, rsp_rdata 0, rsp_err 0, busy 1 and req_ready 0 from the first edge with rst = 1.
- Clear latency: exactly DEPTH cycles after rst deasserts, then req_ready = 1.
- rst asserted mid-CLEAR restarts at ptr 0.
- rst asserted in IDLE discards any pending response: rsp_valid = 0 next cycle.
- Response latency: 1 cycle. A request accepted at edge N gives rsp_valid = 1 during cycle N+1, for one cycle only. There is no backpressure on the response.
- Throughput: one request per cycle in IDLE.
- Store at edge N followed by a load of the same word at edge N+1 returns the new data; no forwarding path is needed.
- req_valid = 0 in a cycle gives rsp_valid = 0 in the following cycle; rsp_rdata and rsp_err are then held at 0.

## Structure

- Package dm_pkg:
  - op encodings DM_WORD, DM_BYTE, DM_HALF, DM_BYTEU, DM_HALFU;
  - state enum {CLEAR, IDLE};
  - function byte_en(op, lane) returning 4 bits.
- Sub-module dm_load_ext (combinational): word, op, lane in; extended 32-bit result out.
- Top-level dm_ctrl holds the memory array, FSM, clear pointer, decode, and response registers.

## Test plan

- Reset with DEPTH = 16, then poll: busy high for 16 cycles, req_ready rises on cycle 16, and a word load of any index returns 0.
- Store word 0x8081_FFFE at BASE+8, then issue loads at BASE+8:
  - byte signed lane 0 -> 0xFFFF_FFFE;
  - byte unsigned lane 3 -> 0x0000_0080;
  - half signed lane 2 -> 0xFFFF_8081;
  - half unsigned lane 0 -> 0x0000_FFFE.
- Store byte 0x12 at BASE+5 over word 0xAABB_CCDD: a word load of BASE+4 -> 0xAABB_12DD. Store half 0x3456 at BASE+6: result 0x3456_12DD.
- Word load at BASE+2, half store at BASE+1, word load at BASE+4*DEPTH, and op 3'b111: all give rsp_err = 1 and rdata 0, and memory is unchanged.
- Back-to-back store then load of the same address on consecutive cycles: the load returns the stored value with rsp_valid on each following cycle.
- Assert rst mid-clear and mid-traffic: clear restarts at 0, no stale rsp_valid appears, and all words read 0 afterwards.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data memory controller: access-size opcodes,
// controller states and the store byte-enable helper.
package dm_pkg;

  // Access opcodes carried on req_op; the remaining codes are illegal.
  localparam logic [2:0] DM_WORD  = 3'b000;
  localparam logic [2:0] DM_BYTE  = 3'b001;
  localparam logic [2:0] DM_HALF  = 3'b010;
  localparam logic [2:0] DM_BYTEU = 3'b011;
  localparam logic [2:0] DM_HALFU = 3'b100;

  // CLEAR zeroes the array one word per cycle; IDLE serves requests.
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } dm_state_e;

  // Byte lanes touched by a store of the given size at the given lane.
  // Illegal ops return no lanes so they can never modify memory.
  function automatic logic [3:0] byte_en(input logic [2:0] op, input logic [1:0] lane);
    logic [3:0] be;
    case (op)
      DM_WORD:           be = 4'b1111;
      DM_HALF, DM_HALFU: be = lane[1] ? 4'b1100 : 4'b0011;
      DM_BYTE, DM_BYTEU: be = 4'b0001 << lane;
      default:           be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Load lane selection and sign/zero extension of a fetched memory word.
module dm_load_ext
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  op,
  input  logic [1:0]  lane,
  output logic [31:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte/half, then extend according to the opcode.
  always_comb begin
    byte_s = word[8*lane +: 8];
    half_s = lane[1] ? word[31:16] : word[15:0];
    case (op)
      DM_WORD:  result = word;
      DM_BYTE:  result = {{24{byte_s[7]}}, byte_s};
      DM_BYTEU: result = {24'h00_0000, byte_s};
      DM_HALF:  result = {{16{half_s[15]}}, half_s};
      DM_HALFU: result = {16'h0000, half_s};
      default:  result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dm_ctrl.sv
// Single-port data memory for the MEM stage: registered response with a
// valid flag, error reporting, and a post-reset clear sequence that zeroes
// one word per cycle before requests are accepted.
module dm_ctrl
  import dm_pkg::*;
#(
  parameter int          DEPTH = 3072,
  parameter logic [31:0] BASE  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int                IDX_W    = $clog2(DEPTH);
  localparam logic [31:0]       LIMIT    = 32'(4 * DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  logic [31:0]      mem_r [DEPTH];
  dm_state_e        state_r;
  logic [IDX_W-1:0] ptr_r;
  logic             req_ready_r;
  logic             busy_r;
  logic             rsp_valid_r;
  logic             rsp_err_r;
  logic [31:0]      rsp_rdata_r;

  logic [31:0]      off_s;
  logic [1:0]       lane_s;
  logic [IDX_W-1:0] idx_s;
  logic             range_err_s;
  logic             align_err_s;
  logic             op_legal_s;
  logic             err_s;
  logic             accept_s;
  logic             store_s;
  logic [3:0]       be_s;
  logic [31:0]      wr_data_s;
  logic [31:0]      rd_word_s;
  logic [31:0]      ext_s;

  assign req_ready = req_ready_r;
  assign busy      = busy_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_rdata = rsp_rdata_r;

  // Address decode, error classification and store data lane replication.
  always_comb begin
    off_s       = req_addr - BASE;
    lane_s      = off_s[1:0];
    idx_s       = off_s[IDX_W+1:2];
    // Wrapped offsets (addresses below BASE) land far above LIMIT.
    range_err_s = (off_s >= LIMIT);
    case (req_op)
      DM_WORD: begin
        op_legal_s  = 1'b1;
        align_err_s = (lane_s != 2'b00);
      end
      DM_HALF, DM_HALFU: begin
        op_legal_s  = 1'b1;
        align_err_s = lane_s[0];
      end
      DM_BYTE, DM_BYTEU: begin
        op_legal_s  = 1'b1;
        align_err_s = 1'b0;
      end
      default: begin
        op_legal_s  = 1'b0;
        align_err_s = 1'b0;
      end
    endcase
    err_s    = range_err_s | align_err_s | ~op_legal_s;
    accept_s = req_valid & req_ready_r;
    store_s  = accept_s & req_we & ~err_s;
    be_s     = byte_en(req_op, lane_s);
    case (req_op)
      DM_BYTE, DM_BYTEU: wr_data_s = {4{req_wdata[7:0]}};
      DM_HALF, DM_HALFU: wr_data_s = {2{req_wdata[15:0]}};
      default:           wr_data_s = req_wdata;
    endcase
    // Non-power-of-two depths leave index codes with no backing word.
    if (range_err_s) begin
      rd_word_s = 32'h0000_0000;
    end else begin
      rd_word_s = mem_r[idx_s];
    end
  end

  dm_load_ext u_load_ext (
    .word   (rd_word_s),
    .op     (req_op),
    .lane   (lane_s),
    .result (ext_s)
  );

  // Memory array: clear writes during CLEAR, byte-enabled stores in IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_r == CLEAR) begin
        mem_r[ptr_r] <= 32'h0000_0000;
      end else if (store_s) begin
        for (int b = 0; b < 4; b++) begin
          if (be_s[b]) begin
            mem_r[idx_s][8*b +: 8] <= wr_data_s[8*b +: 8];
          end
        end
      end
    end
  end

  // Controller FSM with clear pointer and registered handshake/response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= CLEAR;
      ptr_r       <= '0;
      req_ready_r <= 1'b0;
      busy_r      <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        CLEAR: begin
          rsp_valid_r <= 1'b0;
          rsp_err_r   <= 1'b0;
          rsp_rdata_r <= 32'h0000_0000;
          if (ptr_r == LAST_IDX) begin
            state_r     <= IDLE;
            ptr_r       <= '0;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
          end else begin
            ptr_r <= ptr_r + IDX_W'(1);
          end
        end
        IDLE: begin
          rsp_valid_r <= accept_s;
          rsp_err_r   <= accept_s & err_s;
          if (accept_s && !req_we && !err_s) begin
            rsp_rdata_r <= ext_s;
          end else begin
            rsp_rdata_r <= 32'h0000_0000;
          end
        end
        default: begin
          state_r     <= CLEAR;
          ptr_r       <= '0;
          req_ready_r <= 1'b0;
          busy_r      <= 1'b1;
          rsp_valid_r <= 1'b0;
          rsp_err_r   <= 1'b0;
          rsp_rdata_r <= 32'h0000_0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_ctrl.sv
// Self-checking bench for dm_ctrl against a byte-addressed memory model.
module tb_dm_ctrl;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam int          NBYTE = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // Reference memory, little-endian bytes.
  logic [7:0] mb [NBYTE];

  dm_ctrl #(.DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Model one request: returns the expected response and applies stores.
  task automatic model_req(input logic v, input logic we, input logic [2:0] op,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output logic ev, output logic ee, output logic [31:0] er);
    logic [31:0] off;
    int          size;
    bit          sgn;
    longint      val;
    ev = v;
    ee = 1'b0;
    er = 32'h0;
    if (!v) return;
    off  = addr - BASE;
    sgn  = (op == 3'd1) || (op == 3'd2);
    size = (op == 3'd0) ? 4 : (op == 3'd1 || op == 3'd3) ? 1 : (op == 3'd2 || op == 3'd4) ? 2 : 0;
    if (size == 0 || off >= 32'(NBYTE) || (off % 32'(size)) != 0) begin
      ee = 1'b1;
      return;
    end
    if (we) begin
      for (int k = 0; k < size; k++) mb[int'(off) + k] = 8'(wd >> (8 * k));
    end else begin
      val = 0;
      for (int k = 0; k < size; k++) val += longint'(mb[int'(off) + k]) << (8 * k);
      if (sgn && val >= (64'sd1 << (8 * size - 1))) val -= (64'sd1 << (8 * size));
      er = 32'(val);
    end
  endtask

  // One request cycle: drive at negedge, check the response one negedge later.
  task automatic step(input logic v, input logic we, input logic [2:0] op,
                      input logic [31:0] addr, input logic [31:0] wd, input string tag);
    logic ev, ee;
    logic [31:0] er;
    req_valid = v; req_we = we; req_op = op; req_addr = addr; req_wdata = wd;
    model_req(v, we, op, addr, wd, ev, ee, er);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, ".valid"}, {31'h0, rsp_valid}, {31'h0, ev});
    chk({tag, ".err"},   {31'h0, rsp_err},   {31'h0, ee});
    chk({tag, ".rdata"}, rsp_rdata, er);
  endtask

  // Reset pulse (optionally with a request presented on the reset edge), then the clear poll.
  task automatic do_reset(input logic with_req);
    rst = 1'b1;
    req_valid = with_req; req_we = 1'b0; req_op = 3'b000; req_addr = BASE;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst.busy",      {31'h0, busy},      32'd1);
    chk("rst.ready",     {31'h0, req_ready}, 32'd0);
    chk("rst.rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("rst.rsp_err",   {31'h0, rsp_err},   32'd0);
    chk("rst.rdata",     rsp_rdata,          32'd0);
    rst = 1'b0;
    for (int i = 0; i < NBYTE; i++) mb[i] = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("clr.busy",      {31'h0, busy},      (i < DEPTH - 1) ? 32'd1 : 32'd0);
      chk("clr.ready",     {31'h0, req_ready}, (i == DEPTH - 1) ? 32'd1 : 32'd0);
      chk("clr.rsp_valid", {31'h0, rsp_valid}, 32'd0);
    end
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] addr;

    @(negedge clk);
    do_reset(1'b0);
    for (int w = 0; w < DEPTH; w += 5) step(1'b1, 1'b0, 3'd0, BASE + 32'(4 * w), 32'h0, "post_clr_ld");

    // Sub-word loads of one stored word.
    step(1'b1, 1'b1, 3'd0, BASE + 32'd8,  32'h8081_FFFE, "st_w8");
    step(1'b1, 1'b0, 3'd1, BASE + 32'd8,  32'h0, "ld_bs0");
    chk("const_bs0", rsp_rdata, 32'hFFFF_FFFE);
    step(1'b1, 1'b0, 3'd3, BASE + 32'd11, 32'h0, "ld_bu3");
    chk("const_bu3", rsp_rdata, 32'h0000_0080);
    step(1'b1, 1'b0, 3'd2, BASE + 32'd10, 32'h0, "ld_hs2");
    chk("const_hs2", rsp_rdata, 32'hFFFF_8081);
    step(1'b1, 1'b0, 3'd4, BASE + 32'd8,  32'h0, "ld_hu0");
    chk("const_hu0", rsp_rdata, 32'h0000_FFFE);

    // Sub-word stores preserve the other lanes.
    step(1'b1, 1'b1, 3'd0, BASE + 32'd4, 32'hAABB_CCDD, "st_w4");
    step(1'b1, 1'b1, 3'd1, BASE + 32'd5, 32'hFFFF_FF12, "st_b5");
    step(1'b1, 1'b0, 3'd0, BASE + 32'd4, 32'h0, "ld_w4a");
    chk("const_w4a", rsp_rdata, 32'hAABB_12DD);
    step(1'b1, 1'b1, 3'd2, BASE + 32'd6, 32'hEEEE_3456, "st_h6");
    step(1'b1, 1'b0, 3'd0, BASE + 32'd4, 32'h0, "ld_w4b");
    chk("const_w4b", rsp_rdata, 32'h3456_12DD);

    // Error cases leave memory untouched.
    step(1'b1, 1'b0, 3'd0, BASE + 32'd2,  32'h0, "err_ld_mis");
    step(1'b1, 1'b1, 3'd2, BASE + 32'd1,  32'h1234_5678, "err_st_mis");
    step(1'b1, 1'b0, 3'd0, BASE + 32'(NBYTE), 32'h0, "err_ld_oor");
    step(1'b1, 1'b1, 3'd0, BASE - 32'd4,  32'hDEAD_BEEF, "err_st_below");
    step(1'b1, 1'b1, 3'd7, BASE + 32'd8,  32'h5555_5555, "err_st_op7");
    step(1'b1, 1'b0, 3'd7, BASE + 32'd8,  32'h0, "err_ld_op7");
    step(1'b1, 1'b0, 3'd0, BASE + 32'd0,  32'h0, "unch_w0");
    step(1'b1, 1'b0, 3'd0, BASE + 32'd8,  32'h0, "unch_w8");
    step(1'b1, 1'b0, 3'd0, BASE + 32'(NBYTE - 4), 32'h0, "unch_wlast");

    // Back-to-back store/load of the same word, then an idle cycle.
    step(1'b1, 1'b1, 3'd0, BASE + 32'd12, 32'h0BAD_F00D, "b2b_st");
    step(1'b1, 1'b0, 3'd0, BASE + 32'd12, 32'h0, "b2b_ld");
    step(1'b1, 1'b1, 3'd3, BASE + 32'd14, 32'h0000_00C3, "b2b_stb");
    step(1'b1, 1'b0, 3'd1, BASE + 32'd14, 32'h0, "b2b_ldb");
    step(1'b0, 1'b0, 3'd0, BASE, 32'h0, "gap");

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      op = ($urandom % 5 == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 4));
      addr = ($urandom % 16 == 0) ? BASE - 32'($urandom_range(1, 8))
                                  : BASE + 32'($urandom_range(0, NBYTE + 7));
      step(1'($urandom % 8 != 0), 1'($urandom % 2), op, addr, $urandom, "rnd");
    end

    // Reset mid-clear restarts the clear from word 0.
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    do_reset(1'b0);

    // Reset in IDLE with a load on the reset edge: no response, memory cleared.
    for (int w = 0; w < DEPTH; w++) step(1'b1, 1'b1, 3'd0, BASE + 32'(4 * w), $urandom | 32'h1, "fill");
    step(1'b1, 1'b0, 3'd0, BASE, 32'h0, "pre_rst_ld");
    do_reset(1'b1);
    for (int w = 0; w < DEPTH; w++) step(1'b1, 1'b0, 3'd0, BASE + 32'(4 * w), 32'h0, "zero_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
